// File: rtl/venom_pool.sv
// Multi-slot venom projectile pool: allocates shots on fire requests, moves them
// once per frame, retires them at the screen edge or on a hit, and enforces a fire cooldown.
module venom_pool #(
   parameter int NUM_SLOTS = 4,
   parameter int STEP      = 3,
   parameter int SIZE      = 4,
   parameter int X_MAX     = 639,
   parameter int Y_MAX     = 479,
   parameter int COOLDOWN  = 8,
   parameter int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    frame_tick,
   input  logic                    fire_req,
   input  logic [1:0]              fire_dir,
   input  logic [9:0]              snakeX,
   input  logic [9:0]              snakeY,
   input  logic                    hit_valid,
   input  logic [SW-1:0]           hit_slot,
   output logic                    fire_ack,
   output logic [SW-1:0]           fire_slot,
   output logic [NUM_SLOTS-1:0]    active,
   output logic [10*NUM_SLOTS-1:0] VenomX,
   output logic [10*NUM_SLOTS-1:0] VenomY,
   output logic [9:0]              VenomS,
   output logic [SW:0]             free_count,
   output logic                    cooldown_busy
);

   localparam int CW = $clog2(COOLDOWN + 1);

   logic [NUM_SLOTS-1:0] activeQ;
   logic [9:0]           posX [NUM_SLOTS];
   logic [9:0]           posY [NUM_SLOTS];
   logic [1:0]           dirQ [NUM_SLOTS];
   logic [CW-1:0]        coolCnt;
   logic                 fireAckQ;
   logic [SW-1:0]        fireSlotQ;
   logic                 freeFound;
   logic [SW-1:0]        freeIdx;
   logic                 accept;
   logic                 hitOk;
   logic [SW:0]          freeCnt;

   // True when the next move in direction d would leave the screen.
   function automatic logic atEdge(input logic [1:0] d, input logic [9:0] x, input logic [9:0] y);
      case (d)
         2'b00:   return y < 10'(STEP);
         2'b01:   return x < 10'(STEP);
         2'b10:   return ({1'b0, y} + 11'(STEP)) > 11'(Y_MAX);
         default: return ({1'b0, x} + 11'(STEP)) > 11'(X_MAX);
      endcase
   endfunction

   always_comb begin
      freeFound = 1'b0;
      freeIdx   = '0;
      freeCnt   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!activeQ[i]) begin
            freeFound = 1'b1;
            freeIdx   = SW'(i);
            freeCnt   = freeCnt + (SW+1)'(1);
         end
      end
   end

   assign accept = fire_req && (coolCnt == '0) && freeFound;
   assign hitOk  = hit_valid && ({1'b0, hit_slot} < (SW+1)'(NUM_SLOTS));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         activeQ   <= '0;
         coolCnt   <= '0;
         fireAckQ  <= 1'b0;
         fireSlotQ <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            posX[i] <= '0;
            posY[i] <= '0;
            dirQ[i] <= 2'b00;
         end
      end else begin
         fireAckQ <= accept;
         if (accept)
            fireSlotQ <= freeIdx;
         // The accepting edge reloads the counter even when frame_tick coincides.
         if (accept)
            coolCnt <= CW'(COOLDOWN);
         else if (frame_tick && (coolCnt != '0))
            coolCnt <= coolCnt - CW'(1);
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (accept && (freeIdx == SW'(i))) begin
               activeQ[i] <= 1'b1;
               posX[i]    <= snakeX;
               posY[i]    <= snakeY;
               dirQ[i]    <= fire_dir;
            end else if (hitOk && (hit_slot == SW'(i))) begin
               activeQ[i] <= 1'b0;
            end else if (frame_tick && activeQ[i]) begin
               // Retired shots keep their last position; only active says they are gone.
               if (atEdge(dirQ[i], posX[i], posY[i])) begin
                  activeQ[i] <= 1'b0;
               end else begin
                  case (dirQ[i])
                     2'b00:   posY[i] <= posY[i] - 10'(STEP);
                     2'b01:   posX[i] <= posX[i] - 10'(STEP);
                     2'b10:   posY[i] <= posY[i] + 10'(STEP);
                     default: posX[i] <= posX[i] + 10'(STEP);
                  endcase
               end
            end
         end
      end
   end

   always_comb begin
      VenomX = '0;
      VenomY = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         VenomX[10*i +: 10] = posX[i];
         VenomY[10*i +: 10] = posY[i];
      end
   end

   assign fire_ack      = fireAckQ;
   assign fire_slot     = fireSlotQ;
   assign active        = activeQ;
   assign VenomS        = 10'(SIZE);
   assign free_count    = freeCnt;
   assign cooldown_busy = (coolCnt != '0);

endmodule

// File: doc/venom_pool.md
Name: venom_pool

Overview:
- Multi-projectile venom engine for Cobra Combat.
- Holds NUM_SLOTS independent venom shots per snake and allocates a free slot on each accepted fire request.
- Advances every live shot by STEP pixels per frame, retires shots at the screen edge or on a hit report, and enforces a per-snake fire cooldown.
- Sits between the keycode/venom control logic and the collision and colour-mapper blocks.

Parameters:
- NUM_SLOTS, 4, number of concurrent projectiles (1..8).
- STEP, 3, pixels moved per frame_tick.
- SIZE, 4, projectile half-size reported on VenomS.
- X_MAX, 639, rightmost legal X.
- Y_MAX, 479, bottommost legal Y.
- COOLDOWN, 8, frame_ticks after an accepted fire before the next fire is accepted (>=1).
- SW, $clog2(NUM_SLOTS) (min 1), slot index width.

Ports:
- Clk  in  1  system clock (vga_clk domain)
- Reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-Clk pulse per frame (vsync-derived)
- fire_req  in  1  level fire request from the venom key decode
- fire_dir  in  2  direction at fire time: 00=W, 01=A, 10=S, 11=D
- snakeX, snakeY  in  10 each  snake head position, the spawn point
- hit_valid  in  1  collision block reports that a shot struck something
- hit_slot  in  SW  slot index of the struck shot
- fire_ack  out  1  one-Clk pulse: the request was accepted
- fire_slot  out  SW  slot allocated on fire_ack
- active  out  NUM_SLOTS  per-slot live flag
- VenomX, VenomY  out  10*NUM_SLOTS each  packed positions; slot i occupies bits [10i+9:10i]
- VenomS  out  10  constant SIZE
- free_count  out  SW+1  number of non-live slots
- cooldown_busy  out  1  cooldown counter is non-zero

Behaviour:
- Reset (Reset=0, asynchronous):
  - active=0, all VenomX/VenomY=0, per-slot direction=00.
  - Cooldown counter=0, fire_ack=0, fire_slot=0.
  - free_count=NUM_SLOTS, cooldown_busy=0.
  - Reset asserted mid-flight kills all shots immediately.
- Fire acceptance, evaluated each Clk:
  - Accept when fire_req=1, cooldown=0 and at least one slot has active=0 at the start of the cycle.
  - The lowest-index free slot is chosen.
  - On the next edge: active[i]=1, position=(snakeX,snakeY), direction=fire_dir, cooldown=COOLDOWN, fire_ack=1 for exactly one cycle, fire_slot=i.
  - Refusal (no free slot or cooldown non-zero): no state change, fire_ack=0. The request is not queued.
  - fire_req held high re-fires once every COOLDOWN frames while slots remain.
- Cooldown: decrements by 1 on each frame_tick while non-zero and saturates at 0. It is loaded (not decremented) on the accepting edge, even if frame_tick is also high.
- Movement, on a frame_tick cycle for each live slot:
  - W: Y-=STEP; A: X-=STEP; S: Y+=STEP; D: X+=STEP.
  - All arithmetic is unsigned 10-bit and computed from the current position.
- Edge retirement, checked before the move; out-of-range shots are cleared instead of moved:
  - W: Y<STEP.
  - A: X<STEP.
  - S: Y+STEP>Y_MAX.
  - D: X+STEP>X_MAX.
  - Wrap-around is never visible.
  - A retired slot keeps its last position; active=0 is the only validity indicator.
- Hit: hit_valid=1 clears active[hit_slot] on that edge, with priority over movement.
  - A hit on an inactive slot is ignored.
  - A hit_slot >= NUM_SLOTS is ignored.
- Simultaneous events:
  - A slot allocated this cycle is not moved by a coincident frame_tick.
  - A slot hit this cycle is not reusable until the next cycle; allocation uses start-of-cycle active.
  - Fire and hit in the same cycle are both honoured.
- free_count and cooldown_busy are registered-state combinational decodes, consistent with active and the counter every cycle.

Test Plan:
- Reset low with 2 shots live -> active=0, free_count=4, cooldown_busy=0 without any Clk edge; release, single-cycle fire_req with snake (100,200), dir 11 -> fire_ack 1 cycle, fire_slot=0, VenomX[0]=100; after 3 frame_ticks VenomX[0]=109, VenomY[0]=200.
- fire_req held high, COOLDOWN=8 -> acks at frame 0, 8, 16, 24 in slots 0,1,2,3; the fifth request at frame 32 is refused (no fire_ack), free_count=0.
- Shot at X=5, dir 01 -> next tick X=2, following tick retired (active[i]=0), X stays 2; shot at Y=477, dir 10 -> retired on first tick.
- Slots 0-3 live, hit_valid with hit_slot=2 on the same edge as frame_tick -> active=1011, slot 2 position not updated; next accepted fire takes slot 2.
- fire_req accepted in the same cycle as frame_tick -> new shot sits at the snake position for that frame; cooldown reads 8, not 7.
- hit_valid on an inactive slot, and a fire refused during cooldown -> no change to active, positions or cooldown; fire_ack stays 0.
